// File: rtl/k_alu_pkg.sv
// Shared constants for the multi-cycle K_ALU: opcodes, flag bit positions
// and the FSM state encoding.
package k_alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_DIV  = 4'd12;
  localparam logic [3:0] OP_PASS = 4'd13;

  localparam int F_Z = 3;
  localparam int F_N = 2;
  localparam int F_C = 1;
  localparam int F_V = 0;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ITER = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

endpackage

// File: rtl/k_alu_iter.sv
// Shared iterative datapath: WIDTH-step shift-add multiplier and restoring
// divider. lo/hi present the result of the step taken on the next edge.
module k_alu_iter
  import k_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] opnd_q;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             div_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;

  // acc holds the running high half / partial remainder; quo holds the
  // multiplier bits still to consume / the dividend shifting into quotient.
  always_comb begin
    sum     = '0;
    shifted = '0;
    lo      = quo_q;
    hi      = acc_q;
    if (div_q) begin
      shifted = {acc_q, quo_q[WIDTH-1]};
      if (shifted >= {1'b0, opnd_q}) begin
        hi = shifted[WIDTH-1:0] - opnd_q;
        lo = {quo_q[WIDTH-2:0], 1'b1};
      end else begin
        hi = shifted[WIDTH-1:0];
        lo = {quo_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      sum = {1'b0, acc_q} + (quo_q[0] ? {1'b0, opnd_q} : '0);
      hi  = sum[WIDTH:1];
      lo  = {sum[0], quo_q[WIDTH-1:1]};
    end
  end

  assign done = run_q && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q  <= '0;
      quo_q  <= '0;
      opnd_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      div_q  <= 1'b0;
    end else if (start) begin
      acc_q  <= '0;
      quo_q  <= a;
      opnd_q <= b;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      div_q  <= is_div;
    end else if (run_q) begin
      acc_q <= hi;
      quo_q <= lo;
      cnt_q <= cnt_q + CW'(1);
      if (done) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/k_alu_mc.sv
// Multi-cycle WIDTH-bit ALU with valid/ready handshakes. Single-cycle ops
// register their result on the accept edge; MUL/DIV go through k_alu_iter.
module k_alu_mc
  import k_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic [3:0]       flags,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  logic [1:0]       state_q;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] res_hi_q;
  logic [3:0]       flags_q;
  logic             iter_div_q;

  logic             accept;
  logic             go_iter;
  logic             iter_done;
  logic [WIDTH-1:0] iter_lo;
  logic [WIDTH-1:0] iter_hi;

  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] sc_hi;
  logic             sc_c;
  logic             sc_v;
  logic [3:0]       sc_flags;
  logic [3:0]       iter_flags;

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign go_iter   = (sel == OP_MUL) || ((sel == OP_DIV) && (b != '0));
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_ITER);
  assign res       = res_q;
  assign res_hi    = res_hi_q;
  assign flags     = flags_q;

  assign shamt = b[SHW-1:0];
  assign sum   = {1'b0, a} + {1'b0, b};
  assign diff  = {1'b0, a} - {1'b0, b};

  always_comb begin
    sc_res = a;
    sc_hi  = '0;
    sc_c   = 1'b0;
    sc_v   = 1'b0;
    case (sel)
      OP_ADD: begin
        sc_res = sum[WIDTH-1:0];
        sc_c   = sum[WIDTH];
        sc_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        sc_res = diff[WIDTH-1:0];
        sc_c   = ~diff[WIDTH];
        sc_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  sc_res = a & b;
      OP_OR:   sc_res = a | b;
      OP_XOR:  sc_res = a ^ b;
      OP_NOR:  sc_res = ~(a | b);
      OP_SLL:  sc_res = a << shamt;
      OP_SRL:  sc_res = a >> shamt;
      OP_SRA:  sc_res = $signed(a) >>> shamt;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (a < b)};
      // Only reached as a single-cycle op when the divisor is zero.
      OP_DIV: begin
        sc_res = '1;
        sc_hi  = a;
        sc_v   = 1'b1;
      end
      default: sc_res = a;
    endcase
  end

  always_comb begin
    sc_flags         = '0;
    sc_flags[F_Z]    = (sc_res == '0);
    sc_flags[F_N]    = sc_res[WIDTH-1];
    sc_flags[F_C]    = sc_c;
    sc_flags[F_V]    = sc_v;
    iter_flags       = '0;
    iter_flags[F_Z]  = (iter_lo == '0);
    iter_flags[F_N]  = iter_lo[WIDTH-1];
    iter_flags[F_C]  = !iter_div_q && (iter_hi != '0);
    iter_flags[F_V]  = !iter_div_q && (iter_hi != '0);
  end

  k_alu_iter #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (accept && go_iter),
    .is_div (sel == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (iter_done),
    .lo     (iter_lo),
    .hi     (iter_hi)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      res_q      <= '0;
      res_hi_q   <= '0;
      flags_q    <= '0;
      iter_div_q <= 1'b0;
    end else if (accept) begin
      if (go_iter) begin
        state_q    <= ST_ITER;
        iter_div_q <= (sel == OP_DIV);
      end else begin
        state_q  <= ST_DONE;
        res_q    <= sc_res;
        res_hi_q <= sc_hi;
        flags_q  <= sc_flags;
      end
    end else if ((state_q == ST_ITER) && iter_done) begin
      state_q  <= ST_DONE;
      res_q    <= iter_lo;
      res_hi_q <= iter_hi;
      flags_q  <= iter_flags;
    end else if ((state_q == ST_DONE) && out_ready) begin
      state_q <= ST_IDLE;
    end
  end

endmodule
